// File: rtl/scc_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package scc_mem_pkg;

    typedef enum logic {
        ARB_IDLE      = 1'b0,
        ARB_READ_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned LAT_CNT_W   = 3;

endpackage

// File: rtl/arb_lat_counter.sv
// Read-latency down-counter: loads the memory latency on a read grant and
// flags the cycle in which it is about to reach zero.
module arb_lat_counter
    import scc_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic [LAT_CNT_W-1:0] cnt_o,
    output logic                 zero_next_o
);

    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Memory data is valid in the cycle the count steps from 1 to 0.
    assign zero_next_o = dec_i && (cnt_q == LAT_CNT_W'(1));
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified memory port between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is data-over-fetch.
module mem_port_arbiter
    import scc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..%0d", MEM_LAT_MAX);
    end

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;

    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;

    logic grant_if;
    logic grant_d;
    logic is_read;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero_next;
    logic capture;
    logic [LAT_CNT_W-1:0] cnt_val;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q;
`endif

    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if ((state_q == ARB_IDLE) && !reset) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (if_req && d_req) begin
                if (last_owner_q == OWN_D) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
`else
            grant_d  = d_req;
            grant_if = if_req && !d_req;
`endif
        end
    end

    assign is_read = grant_if || (grant_d && !d_we);

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_read  = is_read;
        mem_write = grant_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
    end

    // Reset gating keeps stall low even while both requesters are asserting.
    assign stall = !reset &&
                   ((state_q == ARB_READ_WAIT) ||
                    (if_req && d_req && (state_q == ARB_IDLE)));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (is_read) begin
                    state_d  = ARB_READ_WAIT;
                    owner_d  = grant_d ? OWN_D : OWN_IF;
                    cnt_load = 1'b1;
                end
            end
            ARB_READ_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero_next) begin
                    state_d = ARB_IDLE;
                    capture = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    arb_lat_counter u_lat_cnt (
        .clk         (clk),
        .reset       (reset),
        .load_i      (cnt_load),
        .load_val_i  (LAT_CNT_W'(MEM_LAT)),
        .dec_i       (cnt_dec),
        .cnt_o       (cnt_val),
        .zero_next_o (cnt_zero_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_rvalid_q <= capture && (owner_q == OWN_IF);
            d_rvalid_q  <= capture && (owner_q == OWN_D);
            if (capture && (owner_q == OWN_IF)) begin
                if_rdata_q <= mem_rdata;
            end
            if (capture && (owner_q == OWN_D)) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_IF;
        end else if (grant_if || grant_d) begin
            last_owner_q <= grant_d ? OWN_D : OWN_IF;
        end
    end
`endif

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule
